// File: rtl/gpu_pkg.sv
// Shared types for the shader controller: sequencer states and the
// field layout of a voxel memory word ({x, y, z, id}, x in the MSBs).
package gpu;

    typedef enum logic [3:0] {
        S_IDLE, S_VFETCH, S_PFETCH, S_PLOAD, S_RASTER,
        S_RACK, S_SHADE, S_SACK, S_WRITE, S_FINISH
    } shader_ctrl_state_t;

    // Coordinate slots sit above the palette id, counted upward from z.
    localparam int VOX_X_SLOT = 2;
    localparam int VOX_Y_SLOT = 1;
    localparam int VOX_Z_SLOT = 0;
    localparam int VOX_ID_LSB = 0;

    function automatic int vox_lsb(int slot, int coord_bits, int pal_bits);
        return pal_bits + slot * coord_bits;
    endfunction

endpackage

// File: rtl/shader_controller_frame_scanner.sv
// Raster-order pixel position counter: col runs fastest, wraps into row.
module frame_scanner #(
    parameter int ROW_BITS = 8,
    parameter int COL_BITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                advance,
    input  logic [ROW_BITS-1:0] num_rows,
    input  logic [COL_BITS-1:0] num_cols,
    output logic [ROW_BITS-1:0] row,
    output logic [COL_BITS-1:0] col,
    output logic                last
);

    logic col_wrap;

    assign col_wrap = (col == COL_BITS'(num_cols - 1'b1));
    assign last     = col_wrap && (row == ROW_BITS'(num_rows - 1'b1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shader_controller.sv
// Frame sequencer driving pixel_shader: per pixel, streams every voxel
// through the rasterize handshake, then shades and writes the framebuffer.
module shader_controller
    import gpu::*;
#(
    parameter int ROW_BITS        = 8,
    parameter int COL_BITS        = 8,
    parameter int COORD_BITS      = 8,
    parameter int PALETTE_BITS    = 8,
    parameter int FRAC_BITS       = 8,
    parameter int PIXEL_BITS      = 8,
    parameter int VOXEL_ADDR_BITS = 10
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [ROW_BITS-1:0]                    num_rows,
    input  logic [COL_BITS-1:0]                    num_cols,
    input  logic [VOXEL_ADDR_BITS:0]               voxel_count,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   voxel_rd,
    output logic [VOXEL_ADDR_BITS-1:0]             voxel_addr,
    input  logic [3*COORD_BITS+PALETTE_BITS-1:0]   voxel_rdata,
    output logic                                   pal_rd,
    output logic [PALETTE_BITS-1:0]                pal_addr,
    input  logic [PIXEL_BITS-1:0]                  pal_rdata,
    output logic                                   do_rasterize,
    output logic                                   do_shade,
    output logic [COORD_BITS-1:0]                  voxel_x,
    output logic [COORD_BITS-1:0]                  voxel_y,
    output logic [COORD_BITS-1:0]                  voxel_z,
    output logic [PALETTE_BITS-1:0]                voxel_id,
    output logic [PIXEL_BITS-1:0]                  palette_entry,
    output logic [ROW_BITS-1:0]                    row,
    output logic [COL_BITS-1:0]                    col,
    input  logic                                   rasterizing_done,
    input  logic                                   shading_done,
    input  logic [PIXEL_BITS-1:0]                  pixel,
    output logic                                   fb_we,
    output logic [ROW_BITS-1:0]                    fb_row,
    output logic [COL_BITS-1:0]                    fb_col,
    output logic [PIXEL_BITS-1:0]                  fb_data
);

    localparam int IDX_W = VOXEL_ADDR_BITS + 1;
    localparam int X_LSB = vox_lsb(VOX_X_SLOT, COORD_BITS, PALETTE_BITS);
    localparam int Y_LSB = vox_lsb(VOX_Y_SLOT, COORD_BITS, PALETTE_BITS);
    localparam int Z_LSB = vox_lsb(VOX_Z_SLOT, COORD_BITS, PALETTE_BITS);

    shader_ctrl_state_t state_q, state_d;

    logic [ROW_BITS-1:0]   rows_q;
    logic [COL_BITS-1:0]   cols_q;
    logic [IDX_W-1:0]      count_q, idx_q, idx_next;
    logic [PIXEL_BITS-1:0] pixel_q;
    logic                  ras_ack, shd_ack;
    logic                  scan_clear, scan_adv, scan_last;

    // An ack only counts while our own request is up; requests are only
    // ever high in RASTER/SHADE, so stray acks elsewhere are ignored.
    assign ras_ack  = do_rasterize && rasterizing_done;
    assign shd_ack  = do_shade && shading_done;
    assign idx_next = idx_q + 1'b1;

    assign voxel_addr = idx_q[VOXEL_ADDR_BITS-1:0];
    assign pal_addr   = pal_rd ? voxel_rdata[VOX_ID_LSB +: PALETTE_BITS] : '0;
    assign fb_row     = row;
    assign fb_col     = col;
    assign fb_data    = pixel_q;

    always_comb begin
        state_d    = state_q;
        voxel_rd   = 1'b0;
        pal_rd     = 1'b0;
        fb_we      = 1'b0;
        scan_clear = 1'b0;
        scan_adv   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                scan_clear = 1'b1;
                if (num_rows == '0 || num_cols == '0) state_d = S_FINISH;
                else if (voxel_count == '0)           state_d = S_SHADE;
                else                                  state_d = S_VFETCH;
            end
            S_VFETCH: begin
                voxel_rd = 1'b1;
                state_d  = S_PFETCH;
            end
            S_PFETCH: begin
                pal_rd  = 1'b1;
                state_d = S_PLOAD;
            end
            S_PLOAD:  state_d = S_RASTER;
            S_RASTER: if (ras_ack) state_d = S_RACK;
            S_RACK:   if (!rasterizing_done) state_d = (idx_next < count_q) ? S_VFETCH : S_SHADE;
            S_SHADE:  if (shd_ack) state_d = S_SACK;
            S_SACK:   if (!shading_done) state_d = S_WRITE;
            S_WRITE: begin
                fb_we    = 1'b1;
                scan_adv = 1'b1;
                if (scan_last)           state_d = S_FINISH;
                else if (count_q == '0)  state_d = S_SHADE;
                else                     state_d = S_VFETCH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            do_rasterize  <= 1'b0;
            do_shade      <= 1'b0;
            rows_q        <= '0;
            cols_q        <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            voxel_x       <= '0;
            voxel_y       <= '0;
            voxel_z       <= '0;
            voxel_id      <= '0;
            palette_entry <= '0;
            pixel_q       <= '0;
        end else begin
            state_q      <= state_d;
            busy         <= (state_d != S_IDLE);
            done         <= (state_q == S_FINISH);
            // Requests rise one cycle into RASTER/SHADE and drop on the ack.
            do_rasterize <= (state_q == S_RASTER) && !ras_ack;
            do_shade     <= (state_q == S_SHADE) && !shd_ack;
            if (state_q == S_IDLE && start) begin
                rows_q  <= num_rows;
                cols_q  <= num_cols;
                count_q <= voxel_count;
                idx_q   <= '0;
            end
            if (state_q == S_PFETCH) begin
                voxel_x  <= voxel_rdata[X_LSB +: COORD_BITS];
                voxel_y  <= voxel_rdata[Y_LSB +: COORD_BITS];
                voxel_z  <= voxel_rdata[Z_LSB +: COORD_BITS];
                voxel_id <= voxel_rdata[VOX_ID_LSB +: PALETTE_BITS];
            end
            if (state_q == S_PLOAD) palette_entry <= pal_rdata;
            if (state_q == S_RACK && !rasterizing_done)
                idx_q <= (idx_next < count_q) ? idx_next : '0;
            if (shd_ack) pixel_q <= pixel;
        end
    end

    frame_scanner #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS)
    ) u_scan (
        .clock    (clock),
        .reset    (reset),
        .clear    (scan_clear),
        .advance  (scan_adv),
        .num_rows (rows_q),
        .num_cols (cols_q),
        .row      (row),
        .col      (col),
        .last     (scan_last)
    );

endmodule

// File: doc/shader_controller.md
# shader_controller

Frame-level sequencer that drives `pixel_shader` from the initiator side. For every screen pixel it streams the voxel list from voxel memory, looks up each voxel's palette colour, and runs the `do_rasterize`/`rasterizing_done` handshake once per voxel. It then runs the `do_shade`/`shading_done` handshake and writes the resulting `pixel` into the framebuffer. It sits between the host-facing register block (start/camera) and the `pixel_shader` instance.

## Interface
- `ROW_BITS`, 8, row index width; must match `pixel_shader`
- `COL_BITS`, 8, column index width
- `COORD_BITS`, 8, voxel coordinate integer width
- `PALETTE_BITS`, 8, voxel id / palette address width
- `FRAC_BITS`, 8, camera fixed-point fraction width
- `PIXEL_BITS`, 8, colour width
- `VOXEL_ADDR_BITS`, 10, voxel memory address width
- `clock`  in  1  sole clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-low; all state and outputs go to reset values immediately
- `start`  in  1  one-cycle pulse; begins a frame when idle
- `num_rows`, `num_cols`  in  ROW_BITS / COL_BITS  frame size; sampled at start; 0 in either means an empty frame
- `voxel_count`  in  VOXEL_ADDR_BITS+1  number of voxels; sampled at start
- `busy`  out  1  high from the cycle after an accepted start until `done`
- `done`  out  1  one-cycle pulse when the last framebuffer write completes
- `voxel_rd`, `voxel_addr`  out  1 / VOXEL_ADDR_BITS  voxel memory read; data valid the next cycle
- `voxel_rdata`  in  3*COORD_BITS+PALETTE_BITS  {x, y, z, id}, x in the MSBs
- `pal_rd`, `pal_addr`  out  1 / PALETTE_BITS  palette read; data valid the next cycle
- `pal_rdata`  in  PIXEL_BITS  palette colour
- `do_rasterize`, `do_shade`  out  1  requests to `pixel_shader`
- `voxel_x`, `voxel_y`, `voxel_z`, `voxel_id`, `palette_entry`  out  per params  registered operands; stable while a request is high
- `row`, `col`  out  ROW_BITS / COL_BITS  current pixel
- `rasterizing_done`, `shading_done`  in  1  level acknowledgements from `pixel_shader`
- `pixel`  in  PIXEL_BITS  shaded result; valid while `shading_done` is high
- `fb_we`, `fb_row`, `fb_col`, `fb_data`  out  1 / ROW_BITS / COL_BITS / PIXEL_BITS  framebuffer write port

## Operation
- States: IDLE, VFETCH, PFETCH, PLOAD, RASTER, RACK, SHADE, SACK, WRITE, FINISH.
- IDLE: `start` latches size and count and clears row, col and voxel index.
  - Empty frame (num_rows or num_cols = 0): go to FINISH.
  - `voxel_count` = 0: go to SHADE.
  - Otherwise: go to VFETCH.
- VFETCH: `voxel_rd`=1, `voxel_addr`=index. Next state PFETCH.
- PFETCH: capture `voxel_rdata` into the voxel operand registers; `pal_rd`=1, `pal_addr`=captured id. Next state PLOAD.
- PLOAD: capture `pal_rdata` into `palette_entry`. Next state RASTER.
- RASTER: `do_rasterize`=1 until `rasterizing_done` is sampled high, then go to RACK.
- RACK: `do_rasterize`=0; wait for `rasterizing_done`=0.
  - Then index+1; if index < count go to VFETCH, else clear index and go to SHADE.
- SHADE and SACK: same level handshake using `do_shade`/`shading_done`. `pixel` is captured on the cycle `shading_done` is first sampled high.
- WRITE: `fb_we`=1 for one cycle with the captured pixel at the current row/col.
  - Then advance col; on col = num_cols-1, wrap col to 0 and row+1.
  - After the last pixel, go to FINISH; otherwise go to VFETCH, or SHADE if count = 0.
- FINISH: `done`=1 for one cycle, then IDLE.
- `start` while busy is ignored. An acknowledgement arriving with no request outstanding is ignored.
- Reset values: all outputs 0, state IDLE, all counters 0.

## Timing
- A request rises the cycle after entering RASTER or SHADE. It falls the cycle after its done is sampled high.
- No new request is issued until the previous done has been sampled low. This makes a done that is stuck high for extra cycles safe.
- Per voxel with a 1-cycle acknowledge: VFETCH, PFETCH, PLOAD, RASTER×2, RACK ≥1.
- Write occurs exactly one cycle after SACK sees `shading_done` low.
- Reset asserted mid-frame: the frame is abandoned, requests drop asynchronously, and no `done` or `fb_we` is produced.

## Structure
- Package `gpu`: `shader_ctrl_state_t` enum and the `voxel_rdata` field-slice localparams.
- One natural sub-module: `frame_scanner` (row/col counter with wrap and last-pixel flag).

## Test plan
- 2×2 frame, 1 voxel {1,2,3,id 5}, palette[5]=8'hA0, responder acks after 3 cycles with pixel=row*2+col -> four writes at (0,0),(0,1),(1,0),(1,1) with data 0,1,2,3, one `done`, `pal_addr`=5 each pixel.
- 1×1 frame, 3 voxels -> exactly 3 `do_rasterize` pulses with `voxel_addr` 0,1,2, then 1 `do_shade`, 1 write.
- `voxel_count`=0, 1×2 frame -> no voxel/palette reads, 2 shade handshakes, 2 writes.
- `num_rows`=0 -> `done` pulses 2 cycles after `start`; no requests, no writes.
- `rasterizing_done` held high 5 cycles -> `do_rasterize` low after first sample, next `voxel_rd` only after done falls; `start` pulsed mid-frame is ignored.
- `reset` asserted in SHADE -> `do_shade`, `busy`, `fb_we` all 0 immediately; a new `start` runs a full correct frame.
